// File: rtl/scope_trigger_capture_if.sv
// Sample-input, trigger-control and readout bundle for scope_trigger_capture.
// master = the side feeding samples and reading the window; slave = the capture block.
interface scope_trigger_capture_if #(
  parameter int ADDR_W = 10
);
  logic              sample_valid;
  logic [15:0]       data;
  logic              arm;
  logic              force_trig;
  logic [11:0]       trig_level;
  logic              trig_rising;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic [1:0]        state;
  logic              done;

  modport master (
    output sample_valid, data, arm, force_trig, trig_level, trig_rising, rd_addr,
    input  rd_data, state, done
  );

  modport slave (
    input  sample_valid, data, arm, force_trig, trig_level, trig_rising, rd_addr,
    output rd_data, state, done
  );
endinterface

// File: rtl/scope_trigger_capture.sv
// Edge-triggered scope capture: keeps a circular sample buffer running, fires on a
// level crossing (or a forced trigger), records DEPTH samples with PRE_TRIG of them
// before the trigger, then freezes and serves the window oldest-first by index.
module scope_trigger_capture #(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 512
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  scope_trigger_capture_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_WAIT = 2'd2,
    S_POST = 2'd3
  } state_t;

  // PRE ends on the sample that brings pre_cnt to PRE_TRIG; POST ends on the one
  // that brings post_cnt to DEPTH-PRE_TRIG-1, so compare against the value before it.
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [11:0]       prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              force_pend_q, force_pend_d;
  logic              done_q, done_d;
  logic [11:0]       rd_data_q;
  logic              we;

  logic [11:0]       mem [DEPTH];
  logic [11:0]       cur;
  logic [3:0]        data_unused;
  logic              take;
  logic              edge_hit;
  logic [ADDR_W-1:0] rd_idx;

  assign cur         = bus.data[15:4];
  assign data_unused = bus.data[3:0];
  // A sample is consumed only while a capture is running; arm overrides it.
  assign take        = bus.sample_valid && !bus.arm && (state_q != S_IDLE);
  assign edge_hit    = prev_valid_q &&
                       (bus.trig_rising ? (prev_q < bus.trig_level && cur >= bus.trig_level)
                                        : (prev_q > bus.trig_level && cur <= bus.trig_level));
  assign rd_idx      = start_ptr_q + bus.rd_addr;

  // Next-state and datapath control for the capture sequencer.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = force_pend_q;
    done_d       = done_q;
    we           = 1'b0;

    if (bus.arm) begin
      // Restart from any state; wr_ptr keeps running so the buffer stays circular.
      state_d      = S_PRE;
      done_d       = 1'b0;
      pre_cnt_d    = '0;
      post_cnt_d   = '0;
      prev_valid_d = 1'b0;
      force_pend_d = 1'b0;
    end else begin
      if (bus.force_trig && (state_q == S_PRE || state_q == S_WAIT))
        force_pend_d = 1'b1;
      if (take) begin
        we           = 1'b1;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        prev_d       = cur;
        prev_valid_d = 1'b1;
        unique case (state_q)
          S_PRE: begin
            pre_cnt_d = pre_cnt_q + 1'b1;
            if (pre_cnt_q == PRE_LAST) state_d = S_WAIT;
          end
          S_WAIT: begin
            if (edge_hit || force_pend_q) begin
              // Trigger sample lands at wr_ptr, so the window starts PRE_TRIG behind it.
              start_ptr_d  = wr_ptr_q - PRE_OFS;
              post_cnt_d   = '0;
              force_pend_d = 1'b0;
              state_d      = S_POST;
            end
          end
          S_POST: begin
            post_cnt_d = post_cnt_q + 1'b1;
            if (post_cnt_q == POST_LAST) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      done_q       <= done_d;
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk_100MHz) begin
    if (we) mem[wr_ptr_q] <= cur;
  end

  // Registered readout relative to the window start; read-first on a colliding write.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem[rd_idx];
  end

  assign bus.rd_data = rd_data_q;
  assign bus.state   = state_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Randomised and directed bench for scope_trigger_capture (DEPTH=16, PRE_TRIG=8).
// The reference keeps the full sample history since arm and finds the trigger by
// scanning it, so the expected window is just a slice of that history.
module tb_scope_trigger_capture;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PRE   = 8;
  localparam int POST  = DEPTH - PRE;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  always #5 clk_100MHz = ~clk_100MHz;

  scope_trigger_capture_if #(.ADDR_W(AW)) bus ();

  scope_trigger_capture #(.DEPTH(DEPTH), .ADDR_W(AW), .PRE_TRIG(PRE)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  int h[$];          // samples taken since the last arm
  bit m_armed = 0;
  bit m_done  = 0;
  bit m_pend  = 0;
  int trig_k  = -1;  // index into h of the trigger sample

  function automatic int m_state();
    if (!m_armed)            return 0;
    else if (h.size() < PRE) return 1;
    else if (trig_k < 0)     return 2;
    else                     return 3;
  endfunction

  task automatic model_cycle(input bit arm, input bit sv, input int val,
                             input bit frc, input int lvl, input bit rise);
    int st, k;
    bit fired, edg;
    st    = m_state();
    fired = 0;
    if (arm) begin
      h.delete(); m_armed = 1; m_done = 0; m_pend = 0; trig_k = -1;
      return;
    end
    if (sv && m_armed) begin
      k = h.size();
      h.push_back(val);
      if (trig_k < 0 && k >= PRE) begin
        edg = rise ? (h[k-1] < lvl && val >= lvl) : (h[k-1] > lvl && val <= lvl);
        if (edg || m_pend) begin trig_k = k; fired = 1; end
      end
      if (trig_k >= 0 && h.size() == trig_k + POST) begin m_done = 1; m_armed = 0; end
    end
    if (fired) m_pend = 0;
    else if (frc && (st == 1 || st == 2)) m_pend = 1;
  endtask

  // One clock cycle of stimulus, then model update and state/done check.
  task automatic step(input bit sv, input logic [11:0] val, input bit arm, input bit frc);
    bus.sample_valid = sv;
    bus.data         = {val, 4'($urandom)};
    bus.arm          = arm;
    bus.force_trig   = frc;
    @(posedge clk_100MHz); #1;
    model_cycle(arm, sv, int'(val), frc, int'(bus.trig_level), bus.trig_rising);
    bus.sample_valid = 1'b0;
    bus.arm          = 1'b0;
    bus.force_trig   = 1'b0;
    bus.data         = 16'($urandom);
    chk("state", bus.state, m_state());
    chk("done", bus.done, m_done);
  endtask

  task automatic arm_it();
    step(1'b0, 12'h0, 1'b1, 1'b0);
  endtask

  // Feed a ramp (one strobe every 'every' cycles) until a capture completes.
  task automatic run_ramp(input int start, input int stp, input int every,
                          input int budget, output int n);
    int cyc;
    n = 0; cyc = 0;
    while (!(m_done || bus.done) && cyc < budget) begin
      if (cyc % every == 0) begin
        step(1'b1, 12'(start + stp * n), 1'b0, 1'b0);
        n++;
      end else begin
        step(1'b0, 12'($urandom), 1'b0, 1'b0);
      end
      cyc++;
    end
    chk("capture_complete", bus.done, 1);
  endtask

  task automatic rd(input int a, output logic [11:0] d);
    bus.rd_addr = AW'(a);
    @(posedge clk_100MHz); #1;
    d = bus.rd_data;
  endtask

  task automatic check_window(input string tag);
    logic [11:0] d;
    if (!m_done || trig_k < PRE) return;
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      chk(tag, d, h[trig_k - PRE + i]);
    end
  endtask

  // Window expected for the upward ramp with level 0x200 rising.
  task automatic check_ramp_window(input string tag);
    logic [11:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      chk(tag, d, 32'h180 + 32'h10 * i);
    end
  endtask

  initial begin
    int n, v, lvl;
    logic [11:0] d;
    bus.sample_valid = 0; bus.data = 0; bus.arm = 0; bus.force_trig = 0;
    bus.trig_level = 0; bus.trig_rising = 1; bus.rd_addr = 0;

    // Reset state
    repeat (2) @(posedge clk_100MHz);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;

    // 1: rising ramp through 0x200
    bus.trig_level = 12'h200; bus.trig_rising = 1;
    arm_it();
    run_ramp(0, 16, 1, 200, n);
    check_window("t1_win");
    rd(8, d);  chk("t1_idx8", d, 12'h200);
    rd(7, d);  chk("t1_idx7", d, 12'h1F0);
    rd(0, d);  chk("t1_idx0", d, 12'h180);
    rd(15, d); chk("t1_idx15", d, 12'h270);

    // 2: falling ramp through 0x300
    bus.trig_level = 12'h300; bus.trig_rising = 0;
    arm_it();
    run_ramp(12'h400, -16, 1, 200, n);
    check_window("t2_win");
    rd(8, d);  chk("t2_idx8", d, 12'h300);
    rd(0, d);  chk("t2_idx0", d, 12'h380);
    rd(15, d); chk("t2_idx15", d, 12'h290);

    // 3: constant input, forced trigger during PRE
    bus.trig_level = 12'h800; bus.trig_rising = 1;
    arm_it();
    for (int i = 0; i < 3; i++) step(1'b1, 12'h100, 1'b0, 1'b0);
    step(1'b0, 12'h0, 1'b0, 1'b1);
    run_ramp(12'h100, 0, 1, 200, n);
    chk("t3_samples", n + 3, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin rd(i, d); chk("t3_const", d, 12'h100); end

    // 4: crossing inside PRE is ignored; re-arm in WAIT restarts the count
    bus.trig_level = 12'h200; bus.trig_rising = 1;
    arm_it();
    for (int i = 0; i < 8; i++) step(1'b1, 12'(12'h1C0 + 16 * i), 1'b0, 1'b0);
    step(1'b1, 12'h240, 1'b0, 1'b0);
    step(1'b1, 12'h250, 1'b0, 1'b0);
    chk("t4_wait1", bus.state, 2);
    arm_it();
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2) ? 12'h210 : 12'h1F0, 1'b0, 1'b0);
    step(1'b1, 12'h210, 1'b0, 1'b0);
    step(1'b1, 12'h100, 1'b0, 1'b0);
    chk("t4_wait2", bus.state, 2);
    chk("t4_not_done", bus.done, 0);
    run_ramp(12'h300, 0, 1, 200, n);
    check_window("t4_win");

    // 5: reset in the middle of POST, then a full capture
    bus.trig_level = 12'h200; bus.trig_rising = 1;
    arm_it();
    v = 0;
    while (m_state() != 3 && v < 100) begin step(1'b1, 12'(16 * v), 1'b0, 1'b0); v++; end
    step(1'b1, 12'(16 * v), 1'b0, 1'b0);
    bus.rd_addr = 4'd3;
    @(posedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    chk("t5_state", bus.state, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_rd_data", bus.rd_data, 0);
    h.delete(); m_armed = 0; m_done = 0; m_pend = 0; trig_k = -1;
    @(posedge clk_100MHz); #1 reset = 1'b0;
    arm_it();
    run_ramp(0, 16, 1, 200, n);
    check_ramp_window("t5_win");

    // 6: sparse strobes with junk between them
    arm_it();
    run_ramp(0, 16, 4, 800, n);
    check_ramp_window("t6_win");
    check_window("t6_model");

    // Random captures: random walk data, random level/polarity, stray force/arm
    for (int r = 0; r < 6; r++) begin
      lvl = $urandom_range(12'h100, 12'hE00);
      bus.trig_level  = 12'(lvl);
      bus.trig_rising = 1'($urandom);
      v = lvl + $urandom_range(0, 12'h200) - 12'h100;
      arm_it();
      for (int c = 0; c < 600 && !(m_done || bus.done); c++) begin
        bit sv, frc, rearm;
        v = v + $urandom_range(0, 12'h180) - 12'hC0;
        if (v < 0) v = 0;
        if (v > 12'hFFF) v = 12'hFFF;
        sv    = ($urandom % 3) != 0;
        frc   = (c == 400) || (($urandom % 150) == 0);
        rearm = (c < 300) && (($urandom % 400) == 0);
        step(sv, 12'(v), rearm, frc);
      end
      chk("rnd_complete", bus.done, 1);
      check_window("rnd_win");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
